// File: rtl/lcd_mem_arbiter.sv
// rtl/lcd_mem_arbiter.sv - round-robin arbiter sharing the LCD display RAM between one reader and two writers
// Optional read-hold timeout enabled by defining LCD_ARB_TIMEOUT_EN.

module lcd_mem_arbiter #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 8,
    parameter int RD_LATENCY   = 1,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic              LCD_ARB_CLK,
    input  logic              LCD_ARB_RESET_N,
    input  logic              RD_REQ,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_DATA_ENABLED,
    input  logic              WA_REQ,
    input  logic [ADDR_W-1:0] WA_ADDR,
    input  logic [DATA_W-1:0] WA_DATA,
    output logic              WA_ACK,
    input  logic              WB_REQ,
    input  logic [ADDR_W-1:0] WB_ADDR,
    input  logic [DATA_W-1:0] WB_DATA,
    output logic              WB_ACK,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WE,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [1:0]        ARB_STATE,
    output logic              ARB_TIMEOUT_ERR
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_HOLD = 2'd2,
        WR      = 2'd3
    } state_t;

    localparam int CNT_W = 2;

    state_t              state_q;
    logic [1:0]          last_q;
    logic [CNT_W-1:0]    lat_cnt_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_en_q;
    logic                wa_ack_q;
    logic                wb_ack_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_we_q;

    logic                grant_vld_d;
    logic [1:0]          winner_d;

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(HOLD_TIMEOUT + 1);
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic                tmo_err_q;
`endif

    // Requester 0=RD, 1=WA, 2=WB; search starts just after the last winner.
    always_comb begin
        grant_vld_d = RD_REQ | WA_REQ | WB_REQ;
        winner_d    = 2'd0;
        case (last_q)
            2'd0:    winner_d = WA_REQ ? 2'd1 : (WB_REQ ? 2'd2 : 2'd0);
            2'd1:    winner_d = WB_REQ ? 2'd2 : (RD_REQ ? 2'd0 : 2'd1);
            default: winner_d = RD_REQ ? 2'd0 : (WA_REQ ? 2'd1 : 2'd2);
        endcase
    end

    always_ff @(posedge LCD_ARB_CLK or negedge LCD_ARB_RESET_N) begin
        if (!LCD_ARB_RESET_N) begin
            state_q     <= IDLE;
            last_q      <= 2'd2;
            lat_cnt_q   <= '0;
            rd_data_q   <= '0;
            rd_en_q     <= 1'b0;
            wa_ack_q    <= 1'b0;
            wb_ack_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
            hold_cnt_q  <= '0;
            tmo_err_q   <= 1'b0;
`endif
        end else begin
            wa_ack_q <= 1'b0;
            wb_ack_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        last_q <= winner_d;
                        case (winner_d)
                            2'd0: begin
                                mem_addr_q <= RD_ADDR;
                                lat_cnt_q  <= CNT_W'(RD_LATENCY - 1);
                                state_q    <= RD_WAIT;
                            end
                            2'd1: begin
                                mem_addr_q  <= WA_ADDR;
                                mem_wdata_q <= WA_DATA;
                                mem_we_q    <= 1'b1;
                                wa_ack_q    <= 1'b1;
                                state_q     <= WR;
                            end
                            default: begin
                                mem_addr_q  <= WB_ADDR;
                                mem_wdata_q <= WB_DATA;
                                mem_we_q    <= 1'b1;
                                wb_ack_q    <= 1'b1;
                                state_q     <= WR;
                            end
                        endcase
                    end
                end
                WR: state_q <= IDLE;
                RD_WAIT: begin
                    if (lat_cnt_q == '0) begin
                        // Data is captured even for an abandoned read; only the enable is withheld.
                        rd_data_q <= MEM_RDATA;
                        if (RD_REQ) begin
                            rd_en_q <= 1'b1;
                            state_q <= RD_HOLD;
`ifdef LCD_ARB_TIMEOUT_EN
                            hold_cnt_q <= '0;
`endif
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                RD_HOLD: begin
                    if (!RD_REQ) begin
                        rd_en_q <= 1'b0;
                        state_q <= IDLE;
                    end
`ifdef LCD_ARB_TIMEOUT_EN
                    else if (hold_cnt_q == HOLD_W'(HOLD_TIMEOUT - 1)) begin
                        rd_en_q   <= 1'b0;
                        tmo_err_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign RD_DATA         = rd_data_q;
    assign RD_DATA_ENABLED = rd_en_q;
    assign WA_ACK          = wa_ack_q;
    assign WB_ACK          = wb_ack_q;
    assign MEM_ADDR        = mem_addr_q;
    assign MEM_WDATA       = mem_wdata_q;
    assign MEM_WE          = mem_we_q;
    assign ARB_STATE       = state_q;
`ifdef LCD_ARB_TIMEOUT_EN
    assign ARB_TIMEOUT_ERR = tmo_err_q;
`else
    assign ARB_TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: doc/lcd_mem_arbiter.md
Name: lcd_mem_arbiter

Overview:
- Shares the single-port 512x8 LCD display RAM between three requesters.
- Requester 0 is the LCD line reader, a read-only port with a level-held request and a data-enabled handshake.
- Requester 1 is the temperature formatter, writer A, which writes ASCII digits from the 1-wire sensor path.
- Requester 2 is the status/text writer, writer B.
- Arbitration is round-robin, one RAM access per grant; the RAM sits behind this block only.

Parameters:
ADDR_W, 9, RAM address width
DATA_W, 8, RAM data width
RD_LATENCY, 1, MEM_RDATA valid this many cycles after MEM_ADDR is driven (1..4)
HOLD_TIMEOUT, 1024, max cycles in RD_HOLD (used only with LCD_ARB_TIMEOUT_EN)

Ports:
LCD_ARB_CLK  in  1  clock
LCD_ARB_RESET_N  in  1  reset, asynchronous, active-low
RD_REQ  in  1  reader request, level, held until data taken
RD_ADDR  in  ADDR_W  reader address, stable while RD_REQ high
RD_DATA  out  DATA_W  read data, registered
RD_DATA_ENABLED  out  1  RD_DATA valid; held while RD_REQ high
WA_REQ  in  1  writer A request
WA_ADDR  in  ADDR_W  writer A address
WA_DATA  in  DATA_W  writer A data
WA_ACK  out  1  one-cycle pulse, write performed
WB_REQ  in  1  writer B request
WB_ADDR  in  ADDR_W  writer B address
WB_DATA  in  DATA_W  writer B data
WB_ACK  out  1  one-cycle pulse, write performed
MEM_ADDR  out  ADDR_W  RAM address, registered
MEM_WDATA  out  DATA_W  RAM write data, registered
MEM_WE  out  1  RAM write strobe, one cycle
MEM_RDATA  in  DATA_W  RAM read data
ARB_STATE  out  2  current state, for debug/LED
ARB_TIMEOUT_ERR  out  1  sticky read-hold timeout flag

Behaviour:
- Reset, asynchronous on LCD_ARB_RESET_N low:
  - State IDLE.
  - All outputs 0, including RD_DATA, MEM_ADDR and MEM_WDATA.
  - Latency counter 0.
  - Last-grant pointer LAST=2 (WB), so RD has top priority after reset.
- Reset asserted mid-operation aborts immediately. No ACK and no MEM_WE are issued for the aborted access.
- States and ARB_STATE encoding: IDLE=0, RD_WAIT=1, RD_HOLD=2, WR=3.
- IDLE: evaluate requests in round-robin order starting at LAST+1 (mod 3); the first asserted request wins. LAST is updated to the winner.
  - Winner RD: MEM_ADDR<=RD_ADDR; counter<=RD_LATENCY-1; go to RD_WAIT.
  - Winner WA/WB: MEM_ADDR<=addr, MEM_WDATA<=data, MEM_WE<=1, matching ACK<=1; go to WR.
  - No request: stay in IDLE, MEM_WE=0.
- WR: lasts exactly one cycle.
  - MEM_WE and ACK are high together for this cycle only.
  - Next state IDLE; MEM_WE and ACK cleared.
  - The writer samples ACK and must drop or renew its REQ on the same edge. A REQ still high in the following IDLE cycle is a new write.
- RD_WAIT: counter decrements each cycle.
  - At 0: RD_DATA<=MEM_RDATA.
    - If RD_REQ is still high: RD_DATA_ENABLED<=1, go to RD_HOLD.
    - Else: go to IDLE with RD_DATA_ENABLED kept at 0 (abandoned read completes silently).
- Read latency: RD_DATA_ENABLED rises RD_LATENCY+1 cycles after the IDLE cycle that granted RD.
- RD_HOLD: RD_DATA and RD_DATA_ENABLED stay stable while RD_REQ=1. Changes on RD_ADDR are ignored.
  - RD_REQ=0: RD_DATA_ENABLED<=0 on the next edge, go to IDLE.
- Writer requests arriving during RD_WAIT, RD_HOLD or WR wait; no request is ever dropped.
- Worst-case wait for a writer is one read transaction plus one write.
- Simultaneous RD+WA+WB after reset: grant order RD, WA, WB, RD, …
- MEM_ADDR holds its last value outside accesses. MEM_WDATA changes only on write grants.

Optional Feature:
LCD_ARB_TIMEOUT_EN
- Defined:
  - A counter runs in RD_HOLD.
  - After HOLD_TIMEOUT cycles with RD_REQ still high, the block forces IDLE, clears RD_DATA_ENABLED and sets ARB_TIMEOUT_ERR=1.
  - ARB_TIMEOUT_ERR is cleared only by reset.
  - The stuck RD_REQ then competes normally in the round-robin.
- Undefined: RD_HOLD lasts indefinitely and ARB_TIMEOUT_ERR is tied 0.

Test Plan:
- Reset, then WA_REQ=1, WA_ADDR=0x010, WA_DATA=0x32 -> next cycle MEM_WE=1, MEM_ADDR=0x010, MEM_WDATA=0x32, WA_ACK=1 for exactly 1 cycle; ARB_STATE 3 then 0.
- RAM preloaded with 0x41 at 0x005; RD_REQ=1, RD_ADDR=0x005, RD_LATENCY=1 -> RD_DATA_ENABLED=1 two cycles after grant, RD_DATA=0x41, held while RD_REQ high; drops 1 cycle after RD_REQ falls.
- RD, WA and WB all asserted in the same cycle after reset, each renewing its request after service -> grants RD, WA, WB, RD; writes hit 0x020/0x030 with data 0x31/0x39.
- RD_REQ deasserted during RD_WAIT (RD_LATENCY=3) -> RD_DATA_ENABLED never asserts; state returns to IDLE; a pending WB write is granted next.
- Reset_n pulsed low during WR and during RD_HOLD -> all outputs 0 immediately; no ACK issued; RD wins first after release.
- With LCD_ARB_TIMEOUT_EN and HOLD_TIMEOUT=16: RD_REQ held high -> after 16 RD_HOLD cycles ARB_TIMEOUT_ERR=1 and RD_DATA_ENABLED=0. Without the macro: RD_HOLD persists for 100 cycles and ARB_TIMEOUT_ERR stays 0.
